// File: rtl/pcie_dma_dbg_tap_if.sv
// pcie_dma_dbg_tap_if: snooped DMA request stream plus the debug async-FIFO write side
interface pcie_dma_dbg_tap_if;
    logic        mon_valid;
    logic        mon_ready;
    logic [63:0] mon_data;
    logic        mon_last;
    logic        fifo_wr;
    logic [63:0] fifo_wdata;
    logic        fifo_full;

    modport master (
        input  mon_valid, mon_ready, mon_data, mon_last, fifo_full,
        output fifo_wr, fifo_wdata
    );

    modport slave (
        output mon_valid, mon_ready, mon_data, mon_last, fifo_full,
        input  fifo_wr, fifo_wdata
    );
endinterface

// File: rtl/pcie_dma_dbg_tap.sv
// pcie_dma_dbg_tap: captures the first MAX_BEATS beats of each snooped TLP into a 4-deep queue drained to a debug FIFO
module pcie_dma_dbg_tap #(
    parameter int MAX_BEATS = 2
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_ena,
    input  logic               i_oneshot,
    input  logic               i_clr,
    pcie_dma_dbg_tap_if.master bus,
    output logic [4:0]         o_captured,
    output logic [15:0]        o_dropped,
    output logic               o_stopped
);
    typedef enum logic [1:0] {IDLE, CAPT, SKIP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  idx, idx_nxt;
    logic [63:0] mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        xfer, cap, sel, push, pop, drop;
    logic [4:0]  captured_nxt;

    // The monitored stream is never stalled; only completed transfers move the tap
    assign xfer = bus.mon_valid & bus.mon_ready;
    // The capture decision is frozen at TLP start, so mid-TLP enable/stop changes wait for the next TLP
    assign cap = i_ena & ~o_stopped;
    assign pop = (count != 3'd0) & ~bus.fifo_full;
    // A full queue still accepts a beat when the head leaves in the same cycle
    assign push = sel & ((count != 3'd4) | pop);
    assign drop = sel & ~push;
    assign bus.fifo_wr = pop;
    assign bus.fifo_wdata = mem[rd_ptr];
    assign captured_nxt = (push && o_captured != 5'd16) ? o_captured + 5'd1 : o_captured;

    // TLP tracking: decide per beat whether it is selected and where the TLP walk goes next
    always_comb begin
        state_nxt = state;
        idx_nxt = idx;
        sel = 1'b0;
        if (xfer) begin
            case (state)
                IDLE: begin
                    sel = cap;
                    idx_nxt = 4'd1;
                    state_nxt = bus.mon_last ? IDLE : (MAX_BEATS == 1 || !cap) ? SKIP : CAPT;
                end
                CAPT: begin
                    sel = 1'b1;
                    idx_nxt = idx + 4'd1;
                    state_nxt = bus.mon_last ? IDLE : (int'(idx) + 1 == MAX_BEATS) ? SKIP : CAPT;
                end
                default: state_nxt = bus.mon_last ? IDLE : SKIP;
            endcase
        end
    end

    // TLP tracking state register
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            idx <= '0;
        end else begin
            state <= state_nxt;
            idx <= idx_nxt;
        end
    end

    // Queue storage and pointers; the head entry is presented directly as FIFO write data
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            for (int i = 0; i < 4; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.mon_data;
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
        end
    end

    // Saturating statistics and oneshot stop; a clear pulse overrides any coincident update
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_captured <= '0;
            o_dropped <= '0;
            o_stopped <= 1'b0;
        end else if (i_clr) begin
            o_captured <= '0;
            o_dropped <= '0;
            o_stopped <= 1'b0;
        end else begin
            o_captured <= captured_nxt;
            if (drop && o_dropped != 16'hFFFF) o_dropped <= o_dropped + 16'd1;
            o_stopped <= o_stopped | (i_oneshot & (captured_nxt == 5'd16));
        end
    end
endmodule
